cpu_bus_arbiter: RTL and testbench

Owns the single CPU-side memory bus and shares it between three masters: the instruction engine (IE), the interrupt handler (IH), and an internal OAM sprite DMA engine. The DMA engine is triggered by a CPU write to $4014, halts both IE and IH, and copies 256 bytes from page $XX00-$XXFF to $2004. The block sits between the IE/IH bus ports and the CPU memory map, replacing the ad-hoc busy-flag mux.

---
 rtl/cpu_bus_pkg.sv | 24 ++
 rtl/cpu_bus_arbiter_oam_dma_engine.sv | 118 +++++++++++
 rtl/cpu_bus_arbiter.sv | 100 ++++++++++
 tb/tb_cpu_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared definitions for the CPU bus arbiter slice.
//   - grant encodings (GNT_IE, GNT_IH, GNT_DMA)
//   - default register addresses for the OAM DMA trigger and OAM data port
//   - OAM DMA engine state encoding
package cpu_bus_pkg;

    localparam logic [1:0] GNT_IE  = 2'd0;
    localparam logic [1:0] GNT_IH  = 2'd1;
    localparam logic [1:0] GNT_DMA = 2'd2;

    localparam logic [15:0] DEF_OAM_DMA_ADDR  = 16'h4014;
    localparam logic [15:0] DEF_OAM_DATA_ADDR = 16'h2004;
    localparam int unsigned DEF_DMA_LEN       = 256;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_READ  = 3'd3,
        DMA_WRITE = 3'd4,
        DMA_DONE  = 3'd5
    } dma_state_t;

endpackage

// File: rtl/cpu_bus_arbiter_oam_dma_engine.sv
// oam_dma_engine: OAM sprite DMA state machine.
// Copies one 256-byte page {page,idx} to the OAM data port, one read cycle
// followed by one write cycle per byte.
// Optional macro OAM_DMA_ALIGN_EN: adds a one-cycle ALIGN wait when the
// HALT cycle falls on an odd CPU cycle (parity==1).
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   trigger           start request (only honoured in IDLE)
//   trigger_page      source page latched on trigger
//   mem_data_in       read data, valid the cycle after its address
//   active            state != IDLE (combinational, from the state register)
//   halt, busy        high from HALT through DONE inclusive
//   done              one-cycle pulse during DONE
//   bus_addr/bus_data/bus_we  engine's own bus drive
module oam_dma_engine
    import cpu_bus_pkg::*;
#(
    parameter logic [15:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR,
    parameter logic [7:0]  LAST_IDX      = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic [7:0]  trigger_page,
    input  logic [7:0]  mem_data_in,
    output logic        active,
    output logic        halt,
    output logic        busy,
    output logic        done,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data,
    output logic        bus_we
);

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    dma_state_t state;
    logic [7:0] page;
    logic [7:0] idx;
    logic       parity;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= DMA_IDLE;
            page   <= '0;
            idx    <= '0;
            parity <= 1'b0;
            halt   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            parity <= ~parity;
            done   <= 1'b0;
            case (state)
                DMA_IDLE: begin
                    if (trigger) begin
                        page  <= trigger_page;
                        state <= DMA_HALT;
                        halt  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                DMA_HALT: begin
                    idx   <= '0;
                    state <= (ALIGN_EN && parity) ? DMA_ALIGN : DMA_READ;
                end
`ifdef OAM_DMA_ALIGN_EN
                DMA_ALIGN: begin
                    state <= DMA_READ;
                end
`endif
                DMA_READ: begin
                    state <= DMA_WRITE;
                end
                DMA_WRITE: begin
                    idx <= idx + 8'd1;
                    if (idx == LAST_IDX) begin
                        state <= DMA_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= DMA_READ;
                    end
                end
                DMA_DONE: begin
                    state <= DMA_IDLE;
                    halt  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= DMA_IDLE;
                    halt  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign active = (state != DMA_IDLE);

    // Non-write cycles keep the address inside the source page so idle
    // cycles never touch memory outside it. The write cycle forwards the
    // byte fetched by the preceding read cycle.
    always_comb begin
        bus_addr = {page, idx};
        bus_data = '0;
        bus_we   = 1'b0;
        if (state == DMA_WRITE) begin
            bus_addr = OAM_DATA_ADDR;
            bus_data = mem_data_in;
            bus_we   = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares the CPU memory bus between the instruction engine
// (IE), the interrupt handler (IH) and the internal OAM DMA engine.
// Priority: DMA (while active) > IH (ih_accessing_memory) > IE.
// An IE write to OAM_DMA_ADDR starts a DMA and is not forwarded to memory.
// Optional macro OAM_DMA_ALIGN_EN: odd-cycle alignment wait in the engine.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   ie_addr/ie_data_out/ie_write_en   IE bus request
//   ih_addr/ih_data_out/ih_write_en   IH bus request
//   ih_accessing_memory           IH wants the bus
//   mem_addr/mem_data_out/mem_write_en   bus to the memory map
//   mem_data_in / cpu_data_in     read data from memory, fanned out
//   halt, dma_busy, dma_done      DMA status
//   grant                         0=IE, 1=IH, 2=DMA
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter logic [15:0] OAM_DMA_ADDR  = DEF_OAM_DMA_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR,
    parameter int unsigned DMA_LEN       = DEF_DMA_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ie_addr,
    input  logic [7:0]  ie_data_out,
    input  logic        ie_write_en,
    input  logic [15:0] ih_addr,
    input  logic [7:0]  ih_data_out,
    input  logic        ih_write_en,
    input  logic        ih_accessing_memory,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_out,
    output logic        mem_write_en,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  cpu_data_in,
    output logic        halt,
    output logic        dma_busy,
    output logic        dma_done,
    output logic [1:0]  grant
);

    logic        dma_active;
    logic        trigger;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data;
    logic        dma_we;

    oam_dma_engine #(
        .OAM_DATA_ADDR (OAM_DATA_ADDR),
        .LAST_IDX      (8'(DMA_LEN - 1))
    ) u_dma (
        .clk          (clk),
        .rst          (rst),
        .trigger      (trigger),
        .trigger_page (ie_data_out),
        .mem_data_in  (mem_data_in),
        .active       (dma_active),
        .halt         (halt),
        .busy         (dma_busy),
        .done         (dma_done),
        .bus_addr     (dma_addr),
        .bus_data     (dma_data),
        .bus_we       (dma_we)
    );

    always_comb begin
        if (dma_active) begin
            grant = GNT_DMA;
        end else if (ih_accessing_memory) begin
            grant = GNT_IH;
        end else begin
            grant = GNT_IE;
        end
    end

    // Only the IE can start a DMA; grant==IE already excludes a running DMA.
    assign trigger = (grant == GNT_IE) && ie_write_en && (ie_addr == OAM_DMA_ADDR);

    always_comb begin
        mem_addr     = ie_addr;
        mem_data_out = ie_data_out;
        mem_write_en = ie_write_en && !trigger;
        case (grant)
            GNT_DMA: begin
                mem_addr     = dma_addr;
                mem_data_out = dma_data;
                mem_write_en = dma_we;
            end
            GNT_IH: begin
                mem_addr     = ih_addr;
                mem_data_out = ih_data_out;
                mem_write_en = ih_write_en;
            end
            default: ;
        endcase
    end

    assign cpu_data_in = mem_data_in;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
module tb_cpu_bus_arbiter;
    import cpu_bus_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] ie_addr;
    logic [7:0]  ie_data_out;
    logic        ie_write_en;
    logic [15:0] ih_addr;
    logic [7:0]  ih_data_out;
    logic        ih_write_en;
    logic        ih_accessing_memory;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic        mem_write_en;
    logic [7:0]  mem_data_in;
    logic [7:0]  cpu_data_in;
    logic        halt;
    logic        dma_busy;
    logic        dma_done;
    logic [1:0]  grant;

    cpu_bus_arbiter #(
        .OAM_DMA_ADDR  (16'h4014),
        .OAM_DATA_ADDR (16'h2004),
        .DMA_LEN       (256)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ie_addr             (ie_addr),
        .ie_data_out         (ie_data_out),
        .ie_write_en         (ie_write_en),
        .ih_addr             (ih_addr),
        .ih_data_out         (ih_data_out),
        .ih_write_en         (ih_write_en),
        .ih_accessing_memory (ih_accessing_memory),
        .mem_addr            (mem_addr),
        .mem_data_out        (mem_data_out),
        .mem_write_en        (mem_write_en),
        .mem_data_in         (mem_data_in),
        .cpu_data_in         (cpu_data_in),
        .halt                (halt),
        .dma_busy            (dma_busy),
        .dma_done            (dma_done),
        .grant               (grant)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        bit          chk_src;
        logic [15:0] src;
    } wr_t;

    wr_t         sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    logic [7:0]  memory [0:65535];

    int unsigned halt_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned oob_cnt  = 0;
    int unsigned ih_viol  = 0;
    logic [7:0]  exp_page = 8'h00;
    logic [15:0] prev_addr = 16'h0000;
    logic [15:0] cap_addr = 16'h0000;
    logic [7:0]  cap_data = 8'h00;
    logic        cap_we = 1'b0;
    logic        tb_par;

`define CHECK(tag, obs, exp) \
    begin \
        n_cmp++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, (obs), (exp)); \
        end \
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CPU-cycle parity.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_par <= 1'b0;
        else      tb_par <= ~tb_par;
    end

    // Bus monitor: samples mid-cycle, checks writes against the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        cap_addr = mem_addr;
        cap_we   = mem_write_en;
        cap_data = mem_data_out;
        if (halt === 1'b1) halt_cnt++;
        if (dma_done === 1'b1) done_cnt++;
        if (halt === 1'b1 && grant !== GNT_DMA) ih_viol++;
        if (grant === GNT_DMA && mem_write_en === 1'b0 && mem_addr[15:8] !== exp_page) oob_cnt++;
        if (mem_write_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL unexpected_write: observed addr 'h%0h data 'h%0h, expected no write",
                       mem_addr, mem_data_out);
            end else begin
                e = sb.pop_front();
                `CHECK("wr_addr", mem_addr, e.addr)
                `CHECK("wr_data", mem_data_out, e.data)
                if (e.chk_src) `CHECK("rd_src", prev_addr, e.src)
            end
        end
        prev_addr = mem_addr;
    end

    // Memory model: synchronous read, data valid the cycle after the address.
    always @(posedge clk) begin
        if (cap_we) memory[cap_addr] = cap_data;
        mem_data_in = memory[cap_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dma(input logic [7:0] page);
        for (int i = 0; i < 256; i++) begin
            logic [15:0] s;
            s = {page, 8'(i)};
            sb.push_back('{16'h2004, memory[s], 1'b1, s});
        end
    endtask

    task automatic start_dma(input logic [7:0] page);
        halt_cnt = 0;
        done_cnt = 0;
        oob_cnt  = 0;
        ih_viol  = 0;
        exp_page = page;
        push_dma(page);
        ie_addr     = 16'h4014;
        ie_data_out = page;
        ie_write_en = 1'b1;
        #1;
        `CHECK("trigger_consumed", mem_write_en, 1'b0)
        `CHECK("trigger_not_busy", dma_busy, 1'b0)
        tick();
        ie_write_en = 1'b0;
        ie_addr     = 16'h1234;
        ie_data_out = 8'h00;
    endtask

    task automatic run_dma(input logic [7:0] page, input int unsigned exp_halt, input bit ih_during);
        start_dma(page);
        `CHECK("halt_in_halt_state", halt, 1'b1)
        if (ih_during) begin
            ih_accessing_memory = 1'b1;
            ih_addr             = 16'hFFFA;
        end
        for (int i = 0; i < 1500 && done_cnt == 0; i++) tick();
        `CHECK("done_pulses", done_cnt, 1)
        `CHECK("halt_cycles", halt_cnt, exp_halt)
        `CHECK("writes_left", sb.size(), 0)
        `CHECK("out_of_page", oob_cnt, 0)
        `CHECK("halt_after", halt, 1'b0)
        `CHECK("busy_after", dma_busy, 1'b0)
        if (ih_during) begin
            `CHECK("ih_granted_in_dma", ih_viol, 0)
            `CHECK("ih_resume_grant", grant, GNT_IH)
            `CHECK("ih_resume_addr", mem_addr, 16'hFFFA)
            ih_accessing_memory = 1'b0;
            #1;
        end
        `CHECK("grant_after", grant, GNT_IE)
    endtask

    initial begin
        int unsigned exp_len;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            memory[{8'h02, b}] = b ^ 8'hA5;
            memory[{8'hFF, b}] = ~b ^ 8'h3C;
            memory[{8'h00, b}] = 8'h11;
        end
        mem_data_in         = 8'h00;
        rst                 = 1'b0;
        ie_addr             = 16'h0ABC;
        ie_data_out         = 8'h5A;
        ie_write_en         = 1'b0;
        ih_addr             = 16'h0000;
        ih_data_out         = 8'h00;
        ih_write_en         = 1'b0;
        ih_accessing_memory = 1'b0;

        // Reset state
        #1;
        `CHECK("rst_halt", halt, 1'b0)
        `CHECK("rst_busy", dma_busy, 1'b0)
        `CHECK("rst_done", dma_done, 1'b0)
        `CHECK("rst_grant", grant, GNT_IE)
        `CHECK("rst_addr", mem_addr, 16'h0ABC)
        `CHECK("rst_data", mem_data_out, 8'h5A)
        `CHECK("rst_we", mem_write_en, 1'b0)
        tick();
        tick();
        rst = 1'b1;
        tick();
        `CHECK("cpu_data_fanout", cpu_data_in, mem_data_in)

        // Main transfer from page $02
        run_dma(8'h02, 514, 1'b0);
        tick();

        // IH takes the bus in the same cycle it asks
        ie_addr             = 16'h1234;
        ih_addr             = 16'hFFFA;
        ih_accessing_memory = 1'b1;
        #1;
        `CHECK("ih_same_cycle_addr", mem_addr, 16'hFFFA)
        `CHECK("ih_same_cycle_grant", grant, GNT_IH)
        tick();
        ih_accessing_memory = 1'b0;
        #1;
        `CHECK("ih_release_grant", grant, GNT_IE)
        `CHECK("ih_release_addr", mem_addr, 16'h1234)

        // IH write to $4014 is an ordinary write
        ih_accessing_memory = 1'b1;
        ih_addr             = 16'h4014;
        ih_data_out         = 8'h77;
        ih_write_en         = 1'b1;
        sb.push_back('{16'h4014, 8'h77, 1'b0, 16'h0000});
        #1;
        `CHECK("ih_4014_we", mem_write_en, 1'b1)
        tick();
        ih_write_en         = 1'b0;
        ih_accessing_memory = 1'b0;
        #1;
        `CHECK("ih_4014_no_dma", dma_busy, 1'b0)
        `CHECK("ih_4014_flushed", sb.size(), 0)
        tick();

        // Reset mid-transfer at byte 100, then clean restart from page $FF
        start_dma(8'h02);
        for (int i = 0; i < 600 && sb.size() > 156; i++) tick();
        `CHECK("reached_byte_100", sb.size(), 156)
        #2;
        rst = 1'b0;
        #1;
        `CHECK("abort_halt", halt, 1'b0)
        `CHECK("abort_busy", dma_busy, 1'b0)
        `CHECK("abort_grant", grant, GNT_IE)
        sb.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
        run_dma(8'hFF, 514, 1'b0);
        tick();

        // IH mid-interrupt while IE is halted by DMA
        run_dma(8'h02, 514, 1'b1);
        tick();

        // Both parities of the HALT cycle
        for (int p = 0; p < 2; p++) begin
            if ((~tb_par) !== 1'(p)) tick();
`ifdef OAM_DMA_ALIGN_EN
            exp_len = (p == 1) ? 515 : 514;
`else
            exp_len = 514;
`endif
            run_dma(8'h02, exp_len, 1'b0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
